// File: rtl/mmcm_ps_sequencer.sv
// mmcm_ps_sequencer
// Drives the MMCM dynamic phase-shift port in the psclk domain on behalf of
// the servo loop. Each step is one psen pulse, and only one step is in flight
// at a time. Steps are paced by step_interval idle cycles after every psdone.
// The block tracks the net tap position, suppresses steps that would go past
// +/-POS_LIMIT, and flags a psdone that never arrives or that arrives when
// none was expected.
//
// Ports:
//   clk           psclk, the same clock as the MMCM PSCLK
//   reset_in      asynchronous active-high reset, shared with the MMCM
//   enable        allows new steps; a handshake already in flight always completes
//   step_interval idle cycles between a psdone and the next psen
//   incdec        requested direction (1 = increment, 0 = decrement)
//   clear_err     synchronous clear of the sticky flags; also leaves ERROR
//   psdone        phase-shift done, from the MMCM
//   psen          phase-shift enable to the MMCM (single-cycle pulse)
//   psincdec      direction to the MMCM, held from psen through psdone
//   busy          high while a step is being issued or awaited
//   position      signed net taps applied
//   limit_hit     one-cycle pulse when a step is suppressed at a limit
//   timeout_err   sticky: psdone did not arrive within TIMEOUT_CYCLES
//   spurious_done sticky: psdone seen while no step was outstanding
module mmcm_ps_sequencer #(
  parameter int POS_WIDTH      = 16,
  parameter int POS_LIMIT      = 4096,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int INTERVAL_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset_in,
  input  logic                        enable,
  input  logic [INTERVAL_WIDTH-1:0]   step_interval,
  input  logic                        incdec,
  input  logic                        clear_err,
  input  logic                        psdone,
  output logic                        psen,
  output logic                        psincdec,
  output logic                        busy,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        limit_hit,
  output logic                        timeout_err,
  output logic                        spurious_done
);

  localparam int TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic signed [POS_WIDTH-1:0] POS_MAX = POS_WIDTH'(POS_LIMIT);
  localparam logic signed [POS_WIDTH-1:0] POS_MIN = -POS_MAX;
  localparam logic signed [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);
  localparam logic [TO_WIDTH-1:0] TO_ONE   = TO_WIDTH'(1);
  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [INTERVAL_WIDTH-1:0] INT_ONE = INTERVAL_WIDTH'(1);

  typedef enum logic [1:0] {
    WAIT_INTERVAL,
    ISSUE,
    WAIT_DONE,
    ERROR
  } state_t;

  state_t                      state, state_next;
  logic [INTERVAL_WIDTH-1:0]   interval_count, interval_count_next;
  logic [TO_WIDTH-1:0]         timeout_count, timeout_count_next;
  logic signed [POS_WIDTH-1:0] position_next;
  logic                        psincdec_next;
  logic                        limit_hit_next;
  logic                        timeout_err_next;
  logic                        spurious_done_next;

  // State and output registers. psen and busy are derived from the next state,
  // so they are registered and line up exactly with the ISSUE and WAIT_DONE
  // cycles.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state          <= WAIT_INTERVAL;
      interval_count <= '0;
      timeout_count  <= '0;
      psen           <= 1'b0;
      psincdec       <= 1'b0;
      busy           <= 1'b0;
      position       <= '0;
      limit_hit      <= 1'b0;
      timeout_err    <= 1'b0;
      spurious_done  <= 1'b0;
    end else begin
      state          <= state_next;
      interval_count <= interval_count_next;
      timeout_count  <= timeout_count_next;
      psen           <= (state_next == ISSUE);
      psincdec       <= psincdec_next;
      busy           <= (state_next == ISSUE) || (state_next == WAIT_DONE);
      position       <= position_next;
      limit_hit      <= limit_hit_next;
      timeout_err    <= timeout_err_next;
      spurious_done  <= spurious_done_next;
    end
  end

  // Next-state logic. clear_err is applied first, so an error event in the
  // same cycle overrides it and the flag stays set.
  // The timeout counter holds the number of cycles since psen. The error is
  // registered on the edge where that count reaches TIMEOUT_CYCLES. A psdone
  // in that same cycle still counts as success.
  always_comb begin
    state_next          = state;
    interval_count_next = interval_count;
    timeout_count_next  = timeout_count;
    position_next       = position;
    psincdec_next       = psincdec;
    limit_hit_next      = 1'b0;
    timeout_err_next    = timeout_err;
    spurious_done_next  = spurious_done;

    if (clear_err) begin
      timeout_err_next   = 1'b0;
      spurious_done_next = 1'b0;
    end

    case (state)
      WAIT_INTERVAL: begin
        if (psdone) spurious_done_next = 1'b1;
        if (interval_count != '1) interval_count_next = interval_count + INT_ONE;
        if (enable && (interval_count >= step_interval)) begin
          if ((incdec && (position >= POS_MAX)) || (!incdec && (position <= POS_MIN))) begin
            limit_hit_next      = 1'b1;
            interval_count_next = '0;
          end else begin
            state_next    = ISSUE;
            psincdec_next = incdec;
          end
        end
      end

      ISSUE: begin
        if (psdone) spurious_done_next = 1'b1;
        state_next         = WAIT_DONE;
        timeout_count_next = TO_ONE;
      end

      WAIT_DONE: begin
        if (psdone) begin
          position_next       = psincdec ? (position + POS_ONE) : (position - POS_ONE);
          interval_count_next = '0;
          state_next          = WAIT_INTERVAL;
        end else if ((timeout_count + TO_ONE) == TO_LIMIT) begin
          timeout_err_next = 1'b1;
          state_next       = ERROR;
        end else begin
          timeout_count_next = timeout_count + TO_ONE;
        end
      end

      ERROR: begin
        if (psdone) spurious_done_next = 1'b1;
        if (clear_err) begin
          state_next          = WAIT_INTERVAL;
          interval_count_next = '0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mmcm_ps_sequencer.sv
// tb_mmcm_ps_sequencer
// Directed and randomized bench for mmcm_ps_sequencer. The bench acts as the
// MMCM: it returns psdone after a chosen latency. Expected values come from
// the step rules expressed as arithmetic:
//   - the next psen follows psdone by step_interval + 2 cycles;
//   - position is the running sum of the applied directions.
// A second instance with POS_LIMIT=4 exercises position saturation. Its psdone
// is returned one cycle after each psen.
module tb_mmcm_ps_sequencer;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        enable;
  logic [31:0] step_interval;
  logic        incdec;
  logic        clear_err;
  logic        psdone;
  logic        psen, psincdec, busy, limit_hit, timeout_err, spurious_done;
  logic signed [15:0] position;

  logic        psdone_lim = 1'b0;
  logic        psen_lim, psincdec_lim, busy_lim, limit_hit_lim, timeout_err_lim, spurious_done_lim;
  logic signed [15:0] position_lim;

  int cyc = 0;
  int passed = 0;
  int failed = 0;
  int total = 0;
  int model_pos = 0;
  int t_done = 0;

  mmcm_ps_sequencer dut (
    .clk(clk), .reset_in(reset_in), .enable(enable), .step_interval(step_interval),
    .incdec(incdec), .clear_err(clear_err), .psdone(psdone), .psen(psen),
    .psincdec(psincdec), .busy(busy), .position(position), .limit_hit(limit_hit),
    .timeout_err(timeout_err), .spurious_done(spurious_done)
  );

  mmcm_ps_sequencer #(.POS_LIMIT(4)) dut_lim (
    .clk(clk), .reset_in(reset_in), .enable(enable), .step_interval(step_interval),
    .incdec(incdec), .clear_err(clear_err), .psdone(psdone_lim), .psen(psen_lim),
    .psincdec(psincdec_lim), .busy(busy_lim), .position(position_lim),
    .limit_hit(limit_hit_lim), .timeout_err(timeout_err_lim),
    .spurious_done(spurious_done_lim)
  );

  always #5 clk = ~clk;

  // Cycle index; the bench samples and drives on the falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  // A fixed-latency MMCM stand-in for the limited instance.
  always @(posedge clk) psdone_lim <= psen_lim;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_psen(output int t);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      if (psen === 1'b1) begin
        t = cyc;
        break;
      end
      tick();
    end
    if (t < 0) checkOutput("psen_seen", psen, 1);
  endtask

  // Called in the psen cycle. Returns psdone lat cycles later and checks the
  // hold of psincdec/busy and the updated position. Midway through the wait
  // it sets the direction and interval for the following step.
  task automatic applyStimulus(input int lat, input bit dir, input bit next_dir, input int next_s);
    int bad = 0;
    int mid = (lat + 1) / 2;
    checkOutput("psincdec_at_psen", psincdec, dir);
    checkOutput("busy_at_psen", busy, 1);
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (psen !== 1'b0 || psincdec !== dir || busy !== 1'b1) bad++;
      if (k == mid) begin
        incdec        = next_dir;
        step_interval = next_s;
      end
      if (k == lat) psdone = 1'b1;
    end
    t_done = cyc;
    tick();
    psdone = 1'b0;
    model_pos += dir ? 1 : -1;
    checkOutput("handshake_hold", bad, 0);
    checkOutput("position", position, model_pos);
    checkOutput("busy_after_done", busy, 0);
  endtask

  initial begin
    int p, prev, cnt, cnt_hit, s, ns, lat;
    bit dir, nd;

    reset_in = 1'b1; enable = 1'b0; step_interval = 3; incdec = 1'b1;
    clear_err = 1'b0; psdone = 1'b0;
    repeat (3) tick();
    checkOutput("rst_psen", psen, 0);
    checkOutput("rst_psincdec", psincdec, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_position", position, 0);
    checkOutput("rst_limit_hit", limit_hit, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    checkOutput("rst_spurious", spurious_done, 0);
    reset_in = 1'b0;

    // Disabled: nothing may be issued.
    cnt = 0;
    repeat (20) begin tick(); if (psen) cnt++; end
    checkOutput("idle_psen_count", cnt, 0);
    checkOutput("idle_position", position, 0);
    checkOutput("idle_timeout_err", timeout_err, 0);
    checkOutput("idle_spurious", spurious_done, 0);

    // Five increments with interval 3 and latency 12; the direction flips
    // midway through the fifth handshake.
    enable = 1'b1;
    wait_psen(p);
    prev = p;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(12, 1'b1, (i == 4) ? 1'b0 : 1'b1, 3);
      wait_psen(p);
      checkOutput("psen_period", p - prev, 17);
      checkOutput("gap_after_done", p - t_done, 5);
      prev = p;
    end
    checkOutput("position_after_5", position, 5);

    // Sixth step uses the new direction; dropping enable now has no effect.
    enable = 1'b0;
    applyStimulus(12, 1'b0, 1'b0, 3);
    checkOutput("position_back_to_4", position, 4);
    cnt = 0;
    repeat (30) begin tick(); if (psen) cnt++; end
    checkOutput("disabled_psen_count", cnt, 0);

    // psdone in the last cycle before timeout still counts as success.
    step_interval = 0; incdec = 1'b1; enable = 1'b1;
    wait_psen(p);
    applyStimulus(63, 1'b1, 1'b1, 0);
    checkOutput("latency63_no_timeout", timeout_err, 0);

    // No psdone: timeout 64 cycles after psen.
    wait_psen(p);
    checkOutput("gap_interval0", p - t_done, 2);
    repeat (63) tick();
    checkOutput("timeout_not_yet", timeout_err, 0);
    checkOutput("busy_before_timeout", busy, 1);
    tick();
    checkOutput("timeout_set", timeout_err, 1);
    checkOutput("busy_in_error", busy, 0);
    cnt = 0;
    repeat (20) begin tick(); if (psen) cnt++; end
    checkOutput("error_psen_count", cnt, 0);
    checkOutput("error_position", position, model_pos);

    // A late psdone in ERROR is spurious and does not move the position.
    psdone = 1'b1; tick(); psdone = 1'b0;
    checkOutput("error_spurious", spurious_done, 1);
    checkOutput("error_spurious_pos", position, model_pos);

    // clear_err resumes stepping after step_interval.
    step_interval = 2; clear_err = 1'b1; tick(); clear_err = 1'b0;
    t_done = cyc - 1;
    checkOutput("cleared_timeout", timeout_err, 0);
    checkOutput("cleared_spurious", spurious_done, 0);
    wait_psen(p);
    checkOutput("resume_gap", p - t_done, 4);
    applyStimulus(5, 1'b1, 1'b1, 2);

    // Idle psdone.
    enable = 1'b0;
    repeat (5) tick();
    psdone = 1'b1; tick(); psdone = 1'b0;
    checkOutput("idle_spurious_set", spurious_done, 1);
    checkOutput("idle_spurious_pos", position, model_pos);
    psdone = 1'b1; clear_err = 1'b1; tick(); psdone = 1'b0; clear_err = 1'b0;
    checkOutput("clear_vs_event", spurious_done, 1);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    checkOutput("clear_alone", spurious_done, 0);

    // Randomized steps: interval, latency and direction.
    dir = 1'($urandom_range(0, 1));
    s = int'($urandom_range(0, 6));
    incdec = dir; step_interval = s; enable = 1'b1;
    wait_psen(p);
    for (int i = 0; i < 16; i++) begin
      lat = int'($urandom_range(1, 40));
      nd  = 1'($urandom_range(0, 1));
      ns  = int'($urandom_range(0, 6));
      applyStimulus(lat, dir, nd, ns);
      dir = nd; s = ns;
      wait_psen(p);
      checkOutput("rand_gap", p - t_done, s + 2);
    end

    // Asynchronous reset during WAIT_DONE abandons the step.
    repeat (3) tick();
    #2 reset_in = 1'b1;
    #1;
    model_pos = 0;
    checkOutput("async_rst_psen", psen, 0);
    checkOutput("async_rst_psincdec", psincdec, 0);
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_position", position, model_pos);
    checkOutput("async_rst_timeout", timeout_err, 0);
    checkOutput("async_rst_spurious", spurious_done, 0);
    tick();
    reset_in = 1'b0;

    // Limited instance: increments saturate at +4.
    incdec = 1'b1; step_interval = 0; enable = 1'b1;
    cnt = 0;
    repeat (40) begin tick(); if (psen_lim) cnt++; end
    checkOutput("lim_psen_count", cnt, 4);
    checkOutput("lim_position", position_lim, 4);
    checkOutput("lim_hit_active", limit_hit_lim, 1);
    cnt = 0; cnt_hit = 0;
    repeat (6) begin tick(); if (psen_lim) cnt++; if (limit_hit_lim) cnt_hit++; end
    checkOutput("lim_hit_per_attempt", cnt_hit, 6);
    checkOutput("lim_no_more_psen", cnt, 0);
    enable = 1'b0; tick();
    checkOutput("lim_hit_stops", limit_hit_lim, 0);

    // Decrementing away from the limit is still allowed.
    incdec = 1'b0; enable = 1'b1;
    p = -1;
    for (int i = 0; i < 20; i++) begin
      if (psen_lim === 1'b1) begin p = cyc; break; end
      tick();
    end
    if (p < 0) checkOutput("lim_dec_psen_seen", psen_lim, 1);
    enable = 1'b0;
    repeat (3) tick();
    checkOutput("lim_dec_position", position_lim, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mmcm_ps_sequencer.md
Name: mmcm_ps_sequencer

Overview:
- Psclk-domain stage that drives the MMCM dynamic phase-shift port (psen/psincdec/psdone) on behalf of the servo loop.
- Takes a step interval and a direction from the loop filter, issues single-cycle psen pulses paced by that interval and enforces the one-outstanding-step rule.
- Tracks net phase position in taps, enforces position limits and flags missing or spurious psdone.
- Replaces free-running pulse counters feeding psen directly.

Parameters:
- POS_WIDTH, 16, width of signed net phase position (taps).
- POS_LIMIT, 4096, magnitude limit on position; steps that would exceed ±POS_LIMIT are suppressed.
- TIMEOUT_CYCLES, 64, clk cycles allowed from psen to psdone before error.
- INTERVAL_WIDTH, 32, width of step_interval.

Ports:
- clk  in  1  psclk; same clock as MMCM PSCLK.
- reset_in  in  1  asynchronous, active-high reset.
- enable  in  1  permits new steps; an in-flight handshake always completes.
- step_interval  in  INTERVAL_WIDTH  unsigned idle cycles between psdone and the next psen.
- incdec  in  1  requested direction: 1 = increment, 0 = decrement.
- clear_err  in  1  synchronous clear of sticky error flags; leaves ERROR state.
- psdone  in  1  from MMCM.
- psen  out  1  to MMCM; single-cycle pulse.
- psincdec  out  1  to MMCM; held stable from psen through psdone.
- busy  out  1  high in ISSUE and WAIT_DONE.
- position  out  POS_WIDTH  signed net taps applied.
- limit_hit  out  1  one-cycle pulse when a step is suppressed.
- timeout_err  out  1  sticky flag.
- spurious_done  out  1  sticky flag: psdone seen outside WAIT_DONE.

Behaviour:
- Async reset values: state WAIT_INTERVAL, interval counter 0, psen 0, psincdec 0, busy 0, position 0, limit_hit 0, timeout_err 0, spurious_done 0.
  - Reset mid-handshake abandons the step; position is not updated. The MMCM is reset by the same reset_in.
- States: WAIT_INTERVAL, ISSUE, WAIT_DONE, ERROR. All outputs are registered.
- WAIT_INTERVAL:
  - Counter increments each cycle, saturating at all-ones.
  - When enable=1 and counter >= step_interval, incdec is sampled and checked against the limit.
  - If position+1 > POS_LIMIT (inc) or position-1 < -POS_LIMIT (dec): stay in WAIT_INTERVAL, clear counter, pulse limit_hit for 1 cycle.
  - Otherwise: go to ISSUE and latch psincdec.
- ISSUE: psen=1 for exactly this cycle, then go to WAIT_DONE and clear the timeout counter.
- WAIT_DONE:
  - psen=0; the timeout counter increments.
  - On psdone: position ±1 per the latched psincdec (visible the next cycle), clear the interval counter, go to WAIT_INTERVAL.
  - If the timeout counter reaches TIMEOUT_CYCLES with no psdone: set timeout_err, go to ERROR, position unchanged.
  - psdone in the same cycle the timeout is reached counts as success.
- ERROR:
  - No psen issued.
  - clear_err goes to WAIT_INTERVAL with the counter cleared.
  - A psdone arriving in ERROR sets spurious_done; position is not updated.
- Back-to-back timing with step_interval=0: psdone at cycle t gives WAIT_INTERVAL at t+1 and psen at t+2.
- Pacing in general: psen-to-psen period = psdone latency + step_interval + 2 cycles.
- enable deassert:
  - In WAIT_INTERVAL: blocks issue; the counter keeps running.
  - In ISSUE/WAIT_DONE: no effect.
- psdone in WAIT_INTERVAL or ISSUE: sets spurious_done and is otherwise ignored.
- clear_err clears timeout_err and spurious_done in any state. If clear_err coincides with a new error event, the new event wins (flag set).
- incdec changes outside the sample cycle have no effect on the in-flight step.
- Position arithmetic is signed POS_WIDTH. POS_LIMIT must be < 2^(POS_WIDTH-1), so there is no wrap.

Test Plan:
- Reset, then enable=0 for 20 cycles -> psen never asserts; position=0; all flags 0.
- enable=1, incdec=1, step_interval=3, bench returns psdone 12 cycles after each psen:
  - psen is a 1-cycle pulse with period 17.
  - After 5 psdones, position=5; busy high exactly from the psen cycle to the psdone cycle.
- Same setup with incdec toggled mid-WAIT_DONE:
  - psincdec stays constant until psdone.
  - Next step uses the new direction; position returns to 4.
- POS_LIMIT=4, 10 inc steps with step_interval=0:
  - position saturates at 4.
  - limit_hit pulses once per suppressed attempt; no psen after the 4th step.
- Bench never returns psdone, TIMEOUT_CYCLES=64:
  - timeout_err sets 64 cycles after psen; state ERROR; no further psen.
  - clear_err -> stepping resumes after step_interval.
- Inject psdone while idle; separately assert reset_in during WAIT_DONE:
  - Idle psdone -> spurious_done=1, position unchanged.
  - Reset -> all outputs return to reset values asynchronously.
